// File: rtl/am_modulator.sv
// am_modulator
//
// AM transmitter. A phase accumulator (NCO) drives a quarter-wave sine ROM
// to make the carrier. A held audio sample is turned into an offset,
// depth-scaled and clamped envelope that multiplies the carrier. One 14-bit
// signed sample comes out per sample_en strobe, four cycles after the strobe.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high
//   sample_en       one-cycle strobe; the current phase enters the pipeline
//   phase_inc       carrier frequency word, f = phase_inc * f_s / 2^PHASE_WIDTH
//   phase_inc_load  captures phase_inc into the pending increment register
//   audio           signed modulating sample
//   audio_valid     captures audio into the audio hold register
//   depth           envelope shift 0..3 (larger = less modulation)
//   sample_out      modulated carrier sample, signed
//   sample_valid    one-cycle strobe qualifying sample_out

module am_modulator #(
    parameter int PHASE_WIDTH = 27,
    parameter int OUT_WIDTH   = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_en,
    input  logic [PHASE_WIDTH-1:0]        phase_inc,
    input  logic                          phase_inc_load,
    input  logic signed [15:0]            audio,
    input  logic                          audio_valid,
    input  logic [1:0]                    depth,
    output logic signed [OUT_WIDTH-1:0]   sample_out,
    output logic                          sample_valid
);

    if (OUT_WIDTH != 14) begin : g_out_width_check
        $error("am_modulator: OUT_WIDTH must be 14");
    end

    if (PHASE_WIDTH < 10) begin : g_phase_width_check
        $error("am_modulator: PHASE_WIDTH must be at least 10");
    end

    localparam real PI = 3.14159265358979323846;

    // Quarter-wave table sampled at half-step offsets, so mirroring the index
    // with ~k lands exactly on the symmetric point and needs no special case.
    function automatic logic [14:0] sine_entry(input int i);
        return 15'($rtoi(32767.0 * $sin(PI * (2.0 * i + 1.0) / 1024.0) + 0.5));
    endfunction

    function automatic logic signed [15:0] apply_sign(input logic [14:0] mag,
                                                      input logic        neg);
        logic signed [15:0] m;
        m = signed'({1'b0, mag});
        return neg ? -m : m;
    endfunction

    // Over-modulation: negative envelope clamps to 0, excess to full scale.
    function automatic logic signed [15:0] clamp_env(input logic signed [17:0] raw);
        if (raw < 0)
            return '0;
        else if (raw > 18'sd32767)
            return 16'sd32767;
        else
            return 16'(raw);
    endfunction

    // Floor scaling; |env * carrier| < 2^30 keeps the result inside 14 bits.
    function automatic logic signed [13:0] scale_out(input logic signed [15:0] env,
                                                     input logic signed [15:0] carrier);
        logic signed [31:0] prod;
        prod = env * carrier;
        return 14'(prod >>> 17);
    endfunction

    logic [14:0] rom [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        localparam logic [14:0] ENTRY = sine_entry(gi);
        assign rom[gi] = ENTRY;
    end

    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] inc_active;
    logic [PHASE_WIDTH-1:0] inc_pending;
    logic [PHASE_WIDTH:0]   acc_sum;
    logic [9:0]             addr;

    assign acc_sum = {1'b0, acc} + {1'b0, inc_active};
    assign addr    = acc[PHASE_WIDTH-1 -: 10];

    // The new increment only takes effect when the accumulator wraps, which
    // keeps the carrier phase-continuous. An idle NCO (inc_active == 0) never
    // wraps, so it picks up the pending value on its next strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            inc_active  <= '0;
            inc_pending <= '0;
        end else begin
            if (phase_inc_load)
                inc_pending <= phase_inc;
            if (sample_en) begin
                acc <= acc_sum[PHASE_WIDTH-1:0];
                if (acc_sum[PHASE_WIDTH] || inc_active == '0)
                    inc_active <= inc_pending;
            end
        end
    end

    logic [15:0] audio_hold;
    logic [1:0]  depth_hold;
    logic signed [17:0] env_raw;

    assign env_raw = ($signed({{2{audio_hold[15]}}, audio_hold}) >>> depth_hold)
                     + 18'sd16384;

    logic [7:0]         idx_p0;
    logic               neg_p0;
    logic               vld_p0;
    logic [14:0]        mag_p1;
    logic               neg_p1;
    logic               vld_p1;
    logic signed [15:0] carrier_p2;
    logic signed [15:0] env_p2;
    logic               vld_p2;

    always_ff @(posedge clk) begin
        // p0: quadrant split; odd quadrants read the table backwards
        idx_p0     <= addr[8] ? ~addr[7:0] : addr[7:0];
        neg_p0     <= addr[9];
        // p1: table read
        mag_p1     <= rom[idx_p0];
        neg_p1     <= neg_p0;
        // p2: signed carrier and clamped envelope
        carrier_p2 <= apply_sign(mag_p1, neg_p1);
        env_p2     <= clamp_env(env_raw);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= '0;
            audio_hold   <= '0;
            depth_hold   <= '0;
        end else begin
            vld_p0       <= sample_en;
            vld_p1       <= vld_p0;
            vld_p2       <= vld_p1;
            // p3: multiply, floor shift and output register
            sample_valid <= vld_p2;
            if (vld_p2)
                sample_out <= scale_out(env_p2, carrier_p2);
            if (audio_valid)
                audio_hold <= audio;
            depth_hold   <= depth;
        end
    end

endmodule

// File: tb/tb_am_modulator.sv
// tb_am_modulator
//
// Directed bench for am_modulator. Expected samples are hand-computed from
// the table formula rom[i] = round(32767*sin(2*pi*(i+0.5)/1024)); only the
// entries reached by increments 2^23 and 2^24 are used:
//   rom[0]=101 rom[63]=12446 rom[64]=12632 rom[127]=23099
//   rom[128]=23241 rom[191]=30234 rom[192]=30311 rom[255]=32767
// With env=16384 a sample is floor(c/8); with env=32767 it is
// floor(32767*c/2^17); with env=8192 it is floor(c/16).

module tb_am_modulator;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_en;
    logic [26:0]        phase_inc;
    logic               phase_inc_load;
    logic signed [15:0] audio;
    logic               audio_valid;
    logic [1:0]         depth;
    logic signed [13:0] sample_out;
    logic               sample_valid;

    am_modulator #(.PHASE_WIDTH(27), .OUT_WIDTH(14)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_en      (sample_en),
        .phase_inc      (phase_inc),
        .phase_inc_load (phase_inc_load),
        .audio          (audio),
        .audio_valid    (audio_valid),
        .depth          (depth),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid)
    );

    always #5 clk = ~clk;

    localparam logic [26:0] INC_2_23 = 27'd8388608;
    localparam logic [26:0] INC_2_24 = 27'd16777216;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    bit exp_v;
    int peak;
    int trough;
    int exp_q[$];
    int due_q[$];

    // Phase 0 twice (idle NCO picks up 2^23), then steps of 64 addresses.
    int t_first [20] = '{12, 12, 1579, 2905, 3788, 4095, 3779, 2887, 1555, -13,
                         -1579, -2906, -3789, -4096, -3780, -2888, -1556, 12, 1579, 2905};
    // 2^24 pending from a=192; old step continues until the wrap at a=960.
    int t_mid [18]   = '{3788, 4095, 3779, 2887, 1555, -13, -1579, -2906, -3789,
                         -4096, -3780, -2888, -1556, 12, 2905, 4095, 2887, -13};
    // Load of 2^23 coincides with the wrap at a=896 (index 2); applied one wrap later.
    int t_wrap [14]  = '{-2906, -4096, -2888, 12, 2905, 4095, 2887, -13, -2906,
                         -4096, -2888, 12, 1579, 2905};
    // audio=+32767, depth=0: env clamps to 32767.
    int t_over [16]  = '{7577, 8191, 7558, 5774, 3111, -26, -3158, -5811, -7578,
                         -8192, -7559, -5775, -3112, 25, 3157, 5810};
    // audio=-32768, depth=2: env = 8192, addresses 704..896.
    int t_depth [4]  = '{-1895, -2048, -1890, -1444};

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
            check("valid", sample_valid, exp_v);
            if (exp_v) begin
                check("sample", sample_out, exp_q[0]);
                if (sample_out > peak)   peak   = sample_out;
                if (sample_out < trough) trough = sample_out;
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int exp, input bit ld, input logic [26:0] inc);
        sample_en      = 1'b1;
        phase_inc_load = ld;
        phase_inc      = inc;
        exp_q.push_back(exp);
        due_q.push_back(cyc + 4);
        @(posedge clk);
        #1;
        sample_en      = 1'b0;
        phase_inc_load = 1'b0;
    endtask

    task automatic load_inc(input logic [26:0] inc);
        phase_inc      = inc;
        phase_inc_load = 1'b1;
        idle(1);
        phase_inc_load = 1'b0;
    endtask

    task automatic set_audio(input logic signed [15:0] a, input logic [1:0] d);
        audio       = a;
        depth       = d;
        audio_valid = 1'b1;
        idle(1);
        audio_valid = 1'b0;
        idle(2);
    endtask

    initial begin
        reset          = 1'b1;
        sample_en      = 1'b0;
        phase_inc      = '0;
        phase_inc_load = 1'b0;
        audio          = '0;
        audio_valid    = 1'b0;
        depth          = 2'd1;
        idle(3);
        check("reset_valid", sample_valid, 0);
        check("reset_out", sample_out, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        load_inc(INC_2_23);
        for (int i = 0; i < 20; i++) send(t_first[i], 1'b0, '0);
        idle(6);

        load_inc(INC_2_24);
        for (int i = 0; i < 18; i++) send(t_mid[i], 1'b0, '0);
        idle(6);

        for (int i = 0; i < 14; i++) send(t_wrap[i], (i == 2), INC_2_23);
        idle(6);

        set_audio(16'sd32767, 2'd0);
        peak   = 0;
        trough = 0;
        for (int i = 0; i < 16; i++) send(t_over[i], 1'b0, '0);
        idle(6);
        check("peak", peak, 8191);
        check("trough", trough, -8192);

        set_audio(-16'sd32768, 2'd0);
        for (int i = 0; i < 8; i++) send(0, 1'b0, '0);
        idle(6);

        set_audio(-16'sd32768, 2'd2);
        for (int i = 0; i < 4; i++) send(t_depth[i], 1'b0, '0);
        idle(6);

        // Strobe that must be lost to a reset two cycles later.
        sample_en = 1'b1;
        idle(1);
        sample_en = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midreset_out", sample_out, 0);
        idle(6);

        // First post-reset sample restarts at phase 0 with audio_hold = 0.
        send(12, 1'b0, '0);
        idle(8);
        check("drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
